fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// Instruction fetch stage wrapped around the 32-bit program-counter register: consumes the register's Q and drives its D.
// Fetches from instruction memory over a req/ack handshake and hands instructions downstream over valid/ready.
// Supports branch/jump redirect with stale-response discard, plus a sticky memory-timeout flag.
// The PC register has no enable and loads D every clock, so this block drives pc_d = pc_q whenever the PC must hold.
// PARAMETERS
// RESET_PC        32'h0000_0000  PC value driven into the register while reset is high
// TIMEOUT_CYCLES  64             cycles in S_REQ without imem_ack before err_timeout sets; range 2..65535
// PORTS
// clock          in   1   rising-edge clock shared with the PC register
// reset          in   1   asynchronous, active-high reset
// pc_q           in   32  current PC (PC register Q)
// pc_d           out  32  next PC (PC register D); combinational
// imem_req       out  1   instruction-memory request; level held until imem_ack
// imem_addr      out  32  request address; registered, stable while imem_req=1
// imem_ack       in   1   memory response valid; single-cycle pulse
// imem_rdata     in   32  instruction word, valid when imem_ack=1
// inst_valid     out  1   buffered instruction valid for downstream
// inst_ready     in   1   downstream accepts when inst_valid & inst_ready
// inst_data      out  32  buffered instruction word
// inst_pc        out  32  address the buffered instruction was fetched from
// redirect_valid in   1   branch/jump taken; single cycle
// redirect_pc    in   32  redirect target; bits [1:0] ignored (forced 0)
// err_timeout    out  1   sticky; set on memory timeout, cleared only by reset
// BEHAVIOUR
// - Reset (async): state=S_IDLE; imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, stale=0, err_timeout=0, wait counter=0.
//   pc_d=RESET_PC while reset=1, so pc_q==RESET_PC after the first clock edge in reset.
// - pc_d priority, combinational: reset -> RESET_PC; redirect_valid -> {redirect_pc[31:2],2'b00};
//   S_REQ & imem_ack & !stale -> imem_addr+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0); otherwise pc_q.
// - S_IDLE: imem_req=0.
//   * redirect_valid: remain in S_IDLE for one more cycle so the new PC lands in pc_q first.
//   * otherwise: imem_addr<=pc_q, go to S_REQ.
// - S_REQ: imem_req=1 and imem_addr stable. The wait counter increments each cycle without ack.
//   * Counter reaching TIMEOUT_CYCLES sets err_timeout; the request keeps waiting and the counter saturates.
//   * redirect_valid without ack: stale<=1; stay in S_REQ.
//   * imem_ack & (stale | redirect_valid): discard data, stale<=0, go to S_IDLE.
//   * imem_ack & !stale & !redirect_valid: inst_data<=imem_rdata, inst_pc<=imem_addr, inst_valid<=1, go to S_HOLD.
//   * Any ack clears the wait counter.
// - S_HOLD: inst_valid=1; inst_data and inst_pc stable.
//   * redirect_valid (priority over inst_ready): the instruction is killed and does NOT count as transferred; inst_valid<=0, go to S_IDLE.
//   * inst_ready: transfer; inst_valid<=0, go to S_IDLE.
//   * neither: hold.
// - Throughput: 3 cycles per instruction minimum (IDLE, REQ with zero-wait ack, HOLD with ready). Latency: imem_ack edge -> inst_valid=1 on the next cycle.
// - imem_ack outside S_REQ is ignored.
// - Reset asserted mid-transaction: state drops immediately and any later ack is ignored in S_IDLE. Memory must tolerate an abandoned request.
// STRUCTURE
// - fetch_pkg: typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} fetch_state_t; localparam INSTR_BYTES=4.
// - The 16-bit saturating wait counter with terminal flag is one natural sub-module: fetch_wait_counter. Everything else stays flat.
// - Single always_ff with async reset for state and registers; single always_comb for pc_d, imem_req and next state.
// TESTING
// - Reset with RESET_PC=32'h100, then zero-wait memory returning 32'hDEAD_BEEF, inst_ready=1 -> imem_addr=32'h100;
//   inst_data=32'hDEAD_BEEF with inst_pc=32'h100; pc_q=32'h104; next imem_addr=32'h104.
// - Memory acks 5 cycles late -> imem_req and imem_addr held for 5 cycles; pc_q unchanged until the ack edge; no err_timeout.
// - Redirect to 32'h2003 while in S_REQ, ack 2 cycles later -> first response discarded (inst_valid stays 0); pc_q=32'h2000; next fetch imem_addr=32'h2000.
// - Redirect and imem_ack in the same cycle -> data discarded; pc_q=redirect target; no inst_valid pulse.
// - inst_ready=0 for 10 cycles in S_HOLD -> inst_valid, inst_data and inst_pc stable; no new imem_req.
//   Then redirect together with inst_ready -> instruction killed; next fetch at the target.
// - TIMEOUT_CYCLES=4, no ack for 6 cycles -> err_timeout=1 from cycle 4; ack then completes normally;
//   err_timeout stays 1 until reset, then reads 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_wait_counter.sv
// 16-bit saturating wait counter; hit_o flags the cycle whose increment reaches LIMIT.
module fetch_wait_counter #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 16'd0;
    end else if (inc_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  assign hit_o = inc_i & ~clear_i & (count_q >= LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the external PC register, fetches over req/ack,
// buffers one instruction for a valid/ready consumer, and discards stale responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_q,
  output logic [31:0] pc_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        err_timeout
);

  fetch_state_t state_q, state_d;
  logic [31:0]  imem_addr_q, inst_data_q, inst_pc_q;
  logic         inst_valid_q, stale_q, err_timeout_q;
  logic         in_req_s, wait_hit_s;

  assign in_req_s = (state_q == S_REQ);

  fetch_wait_counter #(.LIMIT(TIMEOUT_CYCLES)) u_wait (
    .clock   (clock),
    .reset   (reset),
    .clear_i (~in_req_s | imem_ack),
    .inc_i   (in_req_s & ~imem_ack),
    .hit_o   (wait_hit_s)
  );

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A redirect spends one idle cycle so the target is in pc_q before it is fetched.
        if (redirect_valid) state_d = S_IDLE;
        else                state_d = S_REQ;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = (stale_q || redirect_valid) ? S_IDLE : S_HOLD;
        else          state_d = S_REQ;
      end
      S_HOLD: begin
        if (redirect_valid || inst_ready) state_d = S_IDLE;
        else                              state_d = S_HOLD;
      end
      default: state_d = S_IDLE;
    endcase

    if (reset) begin
      pc_d = RESET_PC;
    end else if (redirect_valid) begin
      pc_d = align_word(redirect_pc);
    end else if (in_req_s && imem_ack && !stale_q) begin
      pc_d = imem_addr_q + 32'(INSTR_BYTES);
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      imem_addr_q   <= RESET_PC;
      inst_valid_q  <= 1'b0;
      inst_data_q   <= 32'd0;
      inst_pc_q     <= 32'd0;
      stale_q       <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (!redirect_valid) imem_addr_q <= pc_q;
        end
        S_REQ: begin
          if (imem_ack) begin
            stale_q <= 1'b0;
            if (!stale_q && !redirect_valid) begin
              inst_data_q  <= imem_rdata;
              inst_pc_q    <= imem_addr_q;
              inst_valid_q <= 1'b1;
            end
          end else if (redirect_valid) begin
            stale_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid || inst_ready) inst_valid_q <= 1'b0;
        end
        default: ;
      endcase
      if (wait_hit_s) err_timeout_q <= 1'b1;
    end
  end

  assign imem_addr   = imem_addr_q;
  assign inst_valid  = inst_valid_q;
  assign inst_data   = inst_data_q;
  assign inst_pc     = inst_pc_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: two instances share stimulus (TIMEOUT 64 and 4),
// each closing the loop through its own PC register; delivered instructions go through a scoreboard.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_ack, inst_ready, redirect_valid;
  logic [31:0] imem_rdata, redirect_pc;

  logic [31:0] pc_q_a, pc_d_a, imem_addr_a, inst_data_a, inst_pc_a;
  logic        imem_req_a, inst_valid_a, err_a;
  logic [31:0] pc_q_b, pc_d_b, imem_addr_b, inst_data_b, inst_pc_b;
  logic        imem_req_b, inst_valid_b, err_b;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  always_ff @(posedge clock) pc_q_a <= pc_d_a;
  always_ff @(posedge clock) pc_q_b <= pc_d_b;

  fetch_unit #(.RESET_PC(32'h0000_0100), .TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .reset(reset), .pc_q(pc_q_a), .pc_d(pc_d_a),
    .imem_req(imem_req_a), .imem_addr(imem_addr_a), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid_a), .inst_ready(inst_ready), .inst_data(inst_data_a), .inst_pc(inst_pc_a),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .err_timeout(err_a)
  );

  fetch_unit #(.RESET_PC(32'h0000_0100), .TIMEOUT_CYCLES(4)) dut_to (
    .clock(clock), .reset(reset), .pc_q(pc_q_b), .pc_d(pc_d_b),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid_b), .inst_ready(inst_ready), .inst_data(inst_data_b), .inst_pc(inst_pc_b),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .err_timeout(err_b)
  );

  // Scoreboard: every accepted (not killed) handshake pops and compares one expected entry.
  always @(negedge clock) begin
    if (!reset && inst_valid_a && inst_ready && !redirect_valid) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got pc=%h data=%h, required no transfer", inst_pc_a, inst_data_a);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (inst_pc_a !== e.pc || inst_data_a !== e.data) begin
          n_bad++;
          $display("FAIL sb_transfer: got pc=%h data=%h, required pc=%h data=%h",
                   inst_pc_a, inst_data_a, e.pc, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req();
    int t = 0;
    while (imem_req_a !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    n_cmp++;
    if (imem_req_a !== 1'b1) begin
      n_bad++;
      $display("FAIL wait_req: imem_req=%b after %0d cycles, required 1", imem_req_a, t);
    end
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int waits, input bit keep);
    wait_req();
    n_cmp++;
    if (imem_addr_a !== addr) begin
      n_bad++;
      $display("FAIL fetch_addr: got %h, required %h", imem_addr_a, addr);
    end
    for (int i = 0; i < waits; i++) begin
      step();
      n_cmp++;
      if (imem_req_a !== 1'b1 || imem_addr_a !== addr || pc_q_a !== addr) begin
        n_bad++;
        $display("FAIL wait_hold: req=%b addr=%h pc_q=%h, required 1 %h %h", imem_req_a, imem_addr_a, pc_q_a, addr, addr);
      end
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    if (keep) sb_q.push_back('{pc: addr, data: data});
    step();
    imem_ack = 1'b0;
    n_cmp++;
    if (inst_valid_a !== 1'b1 || pc_q_a !== addr + 32'd4) begin
      n_bad++;
      $display("FAIL ack_latency: valid=%b pc_q=%h, required 1 %h", inst_valid_a, pc_q_a, addr + 32'd4);
    end
    if (keep) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ack = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
    step();
    step();
    n_cmp++;
    if (pc_q_a !== 32'h100 || imem_req_a !== 1'b0 || imem_addr_a !== 32'h100 || inst_valid_a !== 1'b0 ||
        inst_data_a !== 32'd0 || inst_pc_a !== 32'd0 || err_a !== 1'b0 || err_b !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: pc_q=%h req=%b addr=%h valid=%b data=%h ipc=%h err=%b/%b, required 100 0 100 0 0 0 0/0",
               pc_q_a, imem_req_a, imem_addr_a, inst_valid_a, inst_data_a, inst_pc_a, err_a, err_b);
    end
    reset = 1'b0;
    inst_ready = 1'b1;
  endtask

  task automatic test_basic();
    fetch(32'h100, 32'hDEAD_BEEF, 0, 1'b1);
    wait_req();
    n_cmp++;
    if (imem_addr_a !== 32'h104) begin
      n_bad++;
      $display("FAIL basic_next_addr: got %h, required 00000104", imem_addr_a);
    end
  endtask

  task automatic test_late_ack();
    fetch(32'h104, 32'h1111_1111, 5, 1'b1);
    n_cmp++;
    if (err_a !== 1'b0) begin
      n_bad++;
      $display("FAIL late_no_timeout: err=%b, required 0", err_a);
    end
  endtask

  task automatic test_redirect_req();
    wait_req();
    redirect_valid = 1'b1; redirect_pc = 32'h2003;
    step();
    redirect_valid = 1'b0;
    n_cmp++;
    if (pc_q_a !== 32'h2000 || imem_req_a !== 1'b1 || inst_valid_a !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_req_pc: pc_q=%h req=%b valid=%b, required 2000 1 0", pc_q_a, imem_req_a, inst_valid_a);
    end
    step();
    imem_ack = 1'b1; imem_rdata = 32'hBADB_AD00;
    step();
    imem_ack = 1'b0;
    n_cmp++;
    if (inst_valid_a !== 1'b0 || pc_q_a !== 32'h2000) begin
      n_bad++;
      $display("FAIL redir_req_discard: valid=%b pc_q=%h, required 0 2000", inst_valid_a, pc_q_a);
    end
    fetch(32'h2000, 32'h2222_2222, 0, 1'b1);
  endtask

  task automatic test_redirect_ack();
    wait_req();
    imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
    redirect_valid = 1'b1; redirect_pc = 32'h3000;
    step();
    imem_ack = 1'b0; redirect_valid = 1'b0;
    n_cmp++;
    if (pc_q_a !== 32'h3000 || inst_valid_a !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_ack: pc_q=%h valid=%b, required 3000 0", pc_q_a, inst_valid_a);
    end
    fetch(32'h3000, 32'h3333_3333, 0, 1'b1);
  endtask

  task automatic test_hold_stall();
    inst_ready = 1'b0;
    fetch(32'h3004, 32'hCAFE_F00D, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (inst_valid_a !== 1'b1 || inst_data_a !== 32'hCAFE_F00D || inst_pc_a !== 32'h3004 || imem_req_a !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_stable: valid=%b data=%h ipc=%h req=%b, required 1 cafef00d 3004 0",
                 inst_valid_a, inst_data_a, inst_pc_a, imem_req_a);
      end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h4000; inst_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    n_cmp++;
    if (inst_valid_a !== 1'b0 || pc_q_a !== 32'h4000) begin
      n_bad++;
      $display("FAIL hold_kill: valid=%b pc_q=%h, required 0 4000", inst_valid_a, pc_q_a);
    end
    fetch(32'h4000, 32'h4444_4444, 0, 1'b1);
  endtask

  task automatic test_timeout();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_cmp++;
    if (err_b !== 1'b0) begin
      n_bad++;
      $display("FAIL to_cleared: err=%b, required 0", err_b);
    end
    wait_req();
    for (int i = 1; i <= 6; i++) begin
      step();
      n_cmp++;
      if (err_b !== (i >= 4) || err_a !== 1'b0) begin
        n_bad++;
        $display("FAIL to_cycle%0d: err_b=%b err_a=%b, required %b 0", i, err_b, err_a, (i >= 4));
      end
    end
    fetch(32'h100, 32'h6666_6666, 0, 1'b1);
    n_cmp++;
    if (err_b !== 1'b1) begin
      n_bad++;
      $display("FAIL to_sticky: err=%b, required 1", err_b);
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if (err_b !== 1'b0) begin
      n_bad++;
      $display("FAIL to_reset: err=%b, required 0", err_b);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    test_reset();
    test_basic();
    test_late_ack();
    test_redirect_req();
    test_redirect_ack();
    test_hold_stall();
    test_timeout();
    step();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
